// File: rtl/video_timing_gen_if.sv
// Timing bus between the video timing generator and its consumers.
// Carries frame_count only when VTG_FRAME_COUNT_EN is defined.
interface video_timing_gen_if #(
   parameter int HW = 11,
   parameter int VW = 10
) ();
   logic          pix_en;
   logic [HW-1:0] hcount;
   logic [VW-1:0] vcount;
   logic          hsync;
   logic          vsync;
   logic          blank;
   logic          at_display_area;
   logic          line_start;
   logic          frame_start;
`ifdef VTG_FRAME_COUNT_EN
   logic [15:0]   frame_count;
`endif

   modport master (
      input  pix_en,
      output hcount, vcount, hsync, vsync, blank, at_display_area,
             line_start, frame_start
`ifdef VTG_FRAME_COUNT_EN
      , output frame_count
`endif
   );

   modport slave (
      output pix_en,
      input  hcount, vcount, hsync, vsync, blank, at_display_area,
             line_start, frame_start
`ifdef VTG_FRAME_COUNT_EN
      , input frame_count
`endif
   );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, blank and strobes.
// Optional 16-bit frame counter enabled by defining VTG_FRAME_COUNT_EN.
module video_timing_gen #(
   parameter int H_ACTIVE  = 1024,
   parameter int H_FP      = 24,
   parameter int H_SYNC    = 136,
   parameter int H_BP      = 160,
   parameter int V_ACTIVE  = 768,
   parameter int V_FP      = 3,
   parameter int V_SYNC    = 6,
   parameter int V_BP      = 29,
   parameter int HSYNC_POL = 0,
   parameter int VSYNC_POL = 0,
   parameter int HW        = 11,
   parameter int VW        = 10
) (
   input  logic                  vga_clock,
   input  logic                  reset,
   video_timing_gen_if.master    vif
);

   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
       HT > (1 << HW) || VT > (1 << VW)) begin : g_bad_params
      $error("video_timing_gen: illegal porch/sync parameters or counter width too small");
   end

   localparam logic [HW-1:0] H_LAST  = HW'(HT - 1);
   localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_LO   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_HI   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST  = VW'(VT - 1);
   localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_LO   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_HI   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          HS_ON   = (HSYNC_POL != 0);
   localparam logic          VS_ON   = (VSYNC_POL != 0);

   function automatic logic in_hwin(input logic [HW-1:0] c,
                                    input logic [HW-1:0] lo,
                                    input logic [HW-1:0] hi);
      return (c >= lo) && (c < hi);
   endfunction

   function automatic logic in_vwin(input logic [VW-1:0] c,
                                    input logic [VW-1:0] lo,
                                    input logic [VW-1:0] hi);
      return (c >= lo) && (c < hi);
   endfunction

   logic [HW-1:0] hcount_p0;
   logic [VW-1:0] vcount_p0;
   logic          hsync_p0;
   logic          vsync_p0;
   logic          blank_p0;
   logic          disp_p0;
   logic          line_start_p0;
   logic          frame_start_p0;

   logic [HW-1:0] h_nxt;
   logic [VW-1:0] v_nxt;
   logic          h_last;
   logic          v_last;
   logic          blank_nxt;

   // Next raster position; all outputs are decoded from it so they register in step
   always_comb begin
      h_last    = (hcount_p0 == H_LAST);
      v_last    = (vcount_p0 == V_LAST);
      h_nxt     = h_last ? '0 : hcount_p0 + 1'b1;
      v_nxt     = vcount_p0;
      if (h_last) begin
         v_nxt = v_last ? '0 : vcount_p0 + 1'b1;
      end
      blank_nxt = (h_nxt >= H_ACT) || (v_nxt >= V_ACT);
   end

   always_ff @(posedge vga_clock) begin
      if (reset) begin
         hcount_p0      <= '0;
         vcount_p0      <= '0;
         hsync_p0       <= ~HS_ON;
         vsync_p0       <= ~VS_ON;
         blank_p0       <= 1'b0;
         disp_p0        <= 1'b1;
         line_start_p0  <= 1'b1;
         frame_start_p0 <= 1'b1;
      end else if (vif.pix_en) begin
         hcount_p0      <= h_nxt;
         vcount_p0      <= v_nxt;
         hsync_p0       <= in_hwin(h_nxt, HS_LO, HS_HI) ? HS_ON : ~HS_ON;
         vsync_p0       <= in_vwin(v_nxt, VS_LO, VS_HI) ? VS_ON : ~VS_ON;
         blank_p0       <= blank_nxt;
         disp_p0        <= ~blank_nxt;
         line_start_p0  <= (h_nxt == '0);
         frame_start_p0 <= (h_nxt == '0) && (v_nxt == '0);
      end
   end

   assign vif.hcount          = hcount_p0;
   assign vif.vcount          = vcount_p0;
   assign vif.hsync           = hsync_p0;
   assign vif.vsync           = vsync_p0;
   assign vif.blank           = blank_p0;
   assign vif.at_display_area = disp_p0;
   assign vif.line_start      = line_start_p0;
   assign vif.frame_start     = frame_start_p0;

`ifdef VTG_FRAME_COUNT_EN
   logic [15:0] frame_count_p0;

   // Counts completed frames; a reset restarts at zero rather than counting as a wrap
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         frame_count_p0 <= '0;
      end else if (vif.pix_en && h_last && v_last) begin
         frame_count_p0 <= frame_count_p0 + 16'd1;
      end
   end

   assign vif.frame_count = frame_count_p0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small-raster DUT under random pix_en/reset plus a default-timing DUT.
module tb_video_timing_gen;
   localparam int HA = 8, HF = 2, HS = 2, HB = 4;
   localparam int VA = 4, VF = 1, VS = 1, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   logic vga_clock = 1'b0;
   logic reset     = 1'b1;
   always #5 vga_clock = ~vga_clock;

   video_timing_gen_if #(.HW(5), .VW(4)) vif ();
   video_timing_gen_if                   vif_d ();

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(1), .VSYNC_POL(0), .HW(5), .VW(4)
   ) dut (
      .vga_clock(vga_clock),
      .reset(reset),
      .vif(vif)
   );

   video_timing_gen dut_d (
      .vga_clock(vga_clock),
      .reset(reset),
      .vif(vif_d)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference state: linear pixel index within the frame, frames completed, cycles since reset
   int p_m  = 0;
   int fc_m = 0;
   int n_d  = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   always @(posedge vga_clock) begin
      if (reset) begin
         p_m    <= 0;
         fc_m   <= 0;
         n_d    <= 0;
         chk_on <= 1'b1;
      end else begin
         n_d <= n_d + 1;
         if (vif.pix_en) begin
            p_m <= (p_m + 1) % FT;
            if (p_m == FT - 1) fc_m <= (fc_m + 1) % 65536;
         end
      end
   end

   always @(negedge vga_clock) begin : compare
      int h, v, hd, vd;
      if (chk_on) begin
         h  = p_m % HT;
         v  = p_m / HT;
         check("hcount",      int'(vif.hcount),          h);
         check("vcount",      int'(vif.vcount),          v);
         check("blank",       int'(vif.blank),           int'(h >= HA || v >= VA));
         check("display",     int'(vif.at_display_area), int'(h < HA && v < VA));
         check("hsync",       int'(vif.hsync),           int'(h >= HA + HF && h < HA + HF + HS));
         check("vsync",       int'(vif.vsync),           int'(!(v >= VA + VF && v < VA + VF + VS)));
         check("line_start",  int'(vif.line_start),      int'(h == 0));
         check("frame_start", int'(vif.frame_start),     int'(p_m == 0));
`ifdef VTG_FRAME_COUNT_EN
         check("frame_count", int'(vif.frame_count),     fc_m);
`endif
         hd = n_d % 1344;
         vd = (n_d / 1344) % 806;
         check("d_hcount",      int'(vif_d.hcount),      hd);
         check("d_vcount",      int'(vif_d.vcount),      vd);
         check("d_hsync",       int'(vif_d.hsync),       int'(!(hd >= 1048 && hd < 1184)));
         check("d_vsync",       int'(vif_d.vsync),       int'(!(vd >= 771 && vd < 777)));
         check("d_blank",       int'(vif_d.blank),       int'(hd >= 1024 || vd >= 768));
         check("d_frame_start", int'(vif_d.frame_start), int'(n_d % (1344 * 806) == 0));
      end
   end

   initial begin
      vif.pix_en   = 1'b0;
      vif_d.pix_en = 1'b1;
      reset        = 1'b1;
      repeat (2) @(negedge vga_clock);
      check("rst_hcount",  int'(vif.hcount),      0);
      check("rst_blank",   int'(vif.blank),       0);
      check("rst_hsync",   int'(vif.hsync),       0);
      check("rst_vsync",   int'(vif.vsync),       1);
      check("rst_fstart",  int'(vif.frame_start), 1);

      reset      = 1'b0;
      vif.pix_en = 1'b1;
      repeat (10) @(negedge vga_clock);
      check("lit_h10",     int'(vif.hcount),      10);
      check("lit_hs10",    int'(vif.hsync),       1);
      check("lit_blank10", int'(vif.blank),       1);
      repeat (6) @(negedge vga_clock);
      check("lit_wrap_h",  int'(vif.hcount),      0);
      check("lit_wrap_v",  int'(vif.vcount),      1);
      check("lit_wrap_ls", int'(vif.line_start),  1);
      check("lit_wrap_fs", int'(vif.frame_start), 0);

      for (int i = 0; i < 8; i++) begin
         vif.pix_en = (i % 2 == 0);
         @(negedge vga_clock);
      end
      check("lit_toggle_h", int'(vif.hcount), 4);

      vif.pix_en = 1'b1;
      repeat (17) @(negedge vga_clock);
      check("lit_52_h", int'(vif.hcount), 5);
      check("lit_52_v", int'(vif.vcount), 2);
      reset = 1'b1;
      repeat (3) @(negedge vga_clock);
      reset = 1'b0;
      check("rel_hcount", int'(vif.hcount),      0);
      check("rel_vcount", int'(vif.vcount),      0);
      check("rel_fstart", int'(vif.frame_start), 1);
      check("rel_blank",  int'(vif.blank),       0);
`ifdef VTG_FRAME_COUNT_EN
      check("rel_fcount", int'(vif.frame_count), 0);
`endif

      repeat (3 * 128) @(negedge vga_clock);
      check("lit_3f_h",      int'(vif.hcount),      0);
      check("lit_3f_fstart", int'(vif.frame_start), 1);
`ifdef VTG_FRAME_COUNT_EN
      check("lit_3f_fcount", int'(vif.frame_count), 3);
`endif

      for (int i = 0; i < 4000; i++) begin
         vif.pix_en = ($urandom_range(0, 3) != 0);
         reset      = ($urandom_range(0, 299) == 0);
         @(negedge vga_clock);
      end
      reset = 1'b0;
      @(negedge vga_clock);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
